// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared modes, 640x480@60 default timing and counter-width helper for the VGA pattern generator
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_GRADIENT = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_BORDER   = 2'd3
  } mode_e;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  function automatic int cnt_width(input int total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/vga_timing_core.sv
// rtl/vga_timing_core.sv - raster counters, sync windows and active-video decode, stalled by pix_en
module vga_timing_core
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = cnt_width(H_TOTAL),
  localparam int VW      = cnt_width(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  output logic [HW-1:0] hc,
  output logic [VW-1:0] vc,
  output logic          h_win,
  output logic          v_win,
  output logic          active
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc <= '0;
      vc <= '0;
    end else if (pix_en) begin
      if (hc == HW'(H_TOTAL - 1)) begin
        hc <= '0;
        if (vc == VW'(V_TOTAL - 1)) vc <= '0;
        else                        vc <= vc + 1'b1;
      end else begin
        hc <= hc + 1'b1;
      end
    end
  end

  // 32-bit compares so a window ending exactly at the total never overflows the counter width
  assign h_win  = (32'(hc) >= 32'(H_ACTIVE + H_FP)) && (32'(hc) < 32'(H_ACTIVE + H_FP + H_SYNC));
  assign v_win  = (32'(vc) >= 32'(V_ACTIVE + V_FP)) && (32'(vc) < 32'(V_ACTIVE + V_FP + V_SYNC));
  assign active = (32'(hc) < 32'(H_ACTIVE)) && (32'(vc) < 32'(V_ACTIVE));

endmodule

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - VGA test-pattern generator: mode latch, pattern mux and aligned output register
// Optional build macro PATTERN_SCROLL_EN adds a per-frame horizontal scroll of the gradient.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = VGA_H_ACTIVE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_ACTIVE  = VGA_V_ACTIVE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CBITS     = 4,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW       = cnt_width(H_TOTAL),
  localparam int VW       = cnt_width(V_TOTAL)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  input  logic [1:0]       mode,
  output logic [CBITS-1:0] red,
  output logic [CBITS-1:0] green,
  output logic [CBITS-1:0] blue,
  output logic             hsync,
  output logic             vsync,
  output logic             activevideo,
  output logic [HW-1:0]    x,
  output logic [VW-1:0]    y,
  output logic             frame_start
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [HW-1:0]    hc;
  logic [VW-1:0]    vc;
  logic             h_win;
  logic             v_win;
  logic             active;
  logic             first_px;
  mode_e            mode_q;
  mode_e            mode_eff;
  logic [15:0]      hx;
  logic [15:0]      vx;
  logic [15:0]      hg;
  logic [HW-1:0]    bar_full;
  logic [2:0]       bar;
  logic [2:0]       bar_c;
  logic [CBITS-1:0] pr;
  logic [CBITS-1:0] pg;
  logic [CBITS-1:0] pb;

  vga_timing_core #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_en (pix_en),
    .hc     (hc),
    .vc     (vc),
    .h_win  (h_win),
    .v_win  (v_win),
    .active (active)
  );

  assign first_px = (hc == '0) && (vc == '0);
  // the pixel that latches a new mode must already be drawn with it
  assign mode_eff = first_px ? mode_e'(mode) : mode_q;
  assign hx = 16'(hc);
  assign vx = 16'(vc);

`ifdef PATTERN_SCROLL_EN
  logic [CBITS+1:0] frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (pix_en && (hc == HW'(H_TOTAL - 1)) && (vc == VW'(V_TOTAL - 1))) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign hg = hx + 16'(frame_cnt);
`else
  assign hg = hx;
`endif

  // remainder columns past the eighth full bar fold into bar 7
  assign bar_full = hc / HW'(BAR_W);
  assign bar      = (32'(bar_full) > 7) ? 3'd7 : bar_full[2:0];
  assign bar_c    = 3'd7 - bar;

  always_comb begin
    pr = '0;
    pg = '0;
    pb = '0;
    case (mode_eff)
      MODE_GRADIENT: begin
        pr = hg[CBITS+1:2];
        pg = vx[CBITS+1:2];
        pb = pr + pg;
      end
      MODE_BARS: begin
        pr = {CBITS{bar_c[2]}};
        pg = {CBITS{bar_c[1]}};
        pb = {CBITS{bar_c[0]}};
      end
      MODE_CHECKER: begin
        pr = {CBITS{hx[5] ^ vx[5]}};
        pg = {CBITS{hx[5] ^ vx[5]}};
        pb = {CBITS{hx[5] ^ vx[5]}};
      end
      MODE_BORDER: begin
        if ((hc == '0) || (hc == HW'(H_ACTIVE - 1)) || (vc == '0) || (vc == VW'(V_ACTIVE - 1))) begin
          pr = '1;
          pg = '1;
          pb = '1;
        end
      end
    endcase
    if (!active) begin
      pr = '0;
      pg = '0;
      pb = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      activevideo <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      mode_q      <= MODE_GRADIENT;
    end else begin
      frame_start <= pix_en && first_px;
      if (pix_en) begin
        red         <= pr;
        green       <= pg;
        blue        <= pb;
        hsync       <= h_win ? HSYNC_POL : ~HSYNC_POL;
        vsync       <= v_win ? VSYNC_POL : ~VSYNC_POL;
        activevideo <= active;
        x           <= hc;
        y           <= vc;
        if (first_px) mode_q <= mode_e'(mode);
      end
    end
  end

endmodule
